// File: rtl/qsys_epcs_sysid_ext.sv
`default_nettype none
// =====================================================================
// qsys_epcs_sysid_ext : Avalon-MM system ID, 64-bit uptime, scratch, ctrl
// Rev 1.0
// =====================================================================
module qsys_epcs_sysid_ext #(
    parameter logic [31:0] ID_VALUE     = 32'h5C72_A4F6,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);
    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_STAMP   = 3'd1;
    localparam logic [2:0] ADDR_UP_LO   = 3'd2;
    localparam logic [2:0] ADDR_UP_HI   = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH = 3'd4;
    localparam logic [2:0] ADDR_CTRL    = 3'd5;
    localparam logic [1:0] LAT_CODE     = 2'(READ_LATENCY);

    logic [63:0] uptime;
    logic [31:0] shadow;
    logic [31:0] scratch;
    logic        lock;
    logic [31:0] read_mux;
    logic        wr_en;
    logic        clear_req;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [31:0]             pipe_data [READ_LATENCY];

    // A simultaneous read wins the bus cycle; the write is dropped.
    assign wr_en     = write & ~read;
    assign clear_req = wr_en && (address == ADDR_CTRL) && writedata[1];

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_ID:      read_mux = ID_VALUE;
            ADDR_STAMP:   read_mux = TIMESTAMP;
            ADDR_UP_LO:   read_mux = uptime[31:0];
            ADDR_UP_HI:   read_mux = shadow;
            ADDR_SCRATCH: read_mux = scratch;
            ADDR_CTRL:    read_mux = {22'd0, LAT_CODE, 7'd0, lock};
            default:      read_mux = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            uptime <= '0;
        end else if (clear_req) begin
            uptime <= '0;
        end else begin
            uptime <= uptime + 64'd1;
        end
    end

    // Shadow captures the high half of the very value whose low half is being read.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (read && (address == ADDR_UP_LO)) begin
            shadow <= uptime[63:32];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scratch <= '0;
            lock    <= 1'b0;
        end else if (wr_en) begin
            if ((address == ADDR_SCRATCH) && !lock) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteenable[i]) begin
                        scratch[8*i +: 8] <= writedata[8*i +: 8];
                    end
                end
            end
            if ((address == ADDR_CTRL) && writedata[0]) begin
                lock <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pipe_valid[0] <= 1'b0;
            pipe_data[0]  <= '0;
        end else begin
            pipe_valid[0] <= read;
            if (read) begin
                pipe_data[0] <= read_mux;
            end
        end
    end

    // Each stage only loads on a valid beat so the output holds its last value.
    for (genvar g = 1; g < READ_LATENCY; g++) begin : g_stage
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                pipe_valid[g] <= 1'b0;
                pipe_data[g]  <= '0;
            end else begin
                pipe_valid[g] <= pipe_valid[g-1];
                if (pipe_valid[g-1]) begin
                    pipe_data[g] <= pipe_data[g-1];
                end
            end
        end
    end

    assign readdata      = pipe_data[READ_LATENCY-1];
    assign readdatavalid = pipe_valid[READ_LATENCY-1];

endmodule
`default_nettype wire
